// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, operand classes and flag indices
package fpu_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        INF  = 2'd1,
        NAN  = 2'd2,
        NORM = 2'd3
    } fp_class_t;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones exponent, 1, 0..0}; callers truncate to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = ((64'd1 << exp_w) - 64'd1) << man_w;
        q = q | (64'd1 << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fpu_mul_round.sv
// rtl/fpu_mul_round.sv - combinational normalise, round-to-nearest-even and pack stage
module fpu_mul_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0]       product,
    input  logic signed [EXP_W+1:0]  esum,
    input  logic                     sign,
    input  fp_class_t                cls,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int SW = EXP_W + 2;
    localparam logic [EXP_W+MAN_W:0] QNAN    = (EXP_W + MAN_W + 1)'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [SW-1:0] EXP_MAX = SW'((1 << EXP_W) - 1);

    logic [PW-1:0]          norm;
    logic signed [SW-1:0]   exp_n;
    logic signed [SW-1:0]   exp_r;
    logic [MAN_W:0]         mant;
    logic                   guard;
    logic                   rnd;
    logic                   sticky;
    logic                   round_up;
    logic [MAN_W+1:0]       rounded;
    logic [MAN_W-1:0]       frac;

    always_comb begin
        // A set MSB means the product is in [2,4): keep it as-is and bump the exponent,
        // otherwise shift left so the hidden bit always sits at the top.
        norm     = product[PW-1] ? product : {product[PW-2:0], 1'b0};
        exp_n    = esum + (product[PW-1] ? SW'(1) : SW'(0));
        mant     = norm[PW-1 -: MAN_W+1];
        guard    = norm[MAN_W];
        rnd      = norm[MAN_W-1];
        sticky   = |norm[MAN_W-2:0];
        round_up = guard & (rnd | sticky | mant[0]);
        rounded  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
        exp_r    = exp_n + (rounded[MAN_W+1] ? SW'(1) : SW'(0));
        frac     = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

        result = '0;
        flags  = '0;
        if (cls == NAN) begin
            result              = QNAN;
            flags[FLAG_INVALID] = 1'b1;
        end else if (cls == INF) begin
            result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls == ZERO) begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (exp_r >= EXP_MAX) begin
            result               = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end else if (exp_r <= 0) begin
            result                = {sign, {(EXP_W+MAN_W){1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            result              = {sign, exp_r[EXP_W-1:0], frac};
            flags[FLAG_INEXACT] = guard | rnd | sticky;
        end
    end

endmodule

// File: rtl/fpu_multiplier_pipelined.sv
// rtl/fpu_multiplier_pipelined.sv - three-stage IEEE-754 multiplier with valid/ready handshake
module fpu_multiplier_pipelined
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               out_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = EXP_W + 2;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int BIAS = fp_bias(EXP_W);

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)
            return ZERO;
        if (e == '1)
            return (f == '0) ? INF : NAN;
        return NORM;
    endfunction

    logic                   advance;
    fp_class_t              cls_a;
    fp_class_t              cls_b;
    fp_class_t              cls_c;
    logic signed [SW-1:0]   esum_c;

    logic                   s1_valid;
    logic                   s1_sign;
    fp_class_t              s1_cls;
    logic signed [SW-1:0]   s1_esum;
    logic [MAN_W:0]         s1_man_a;
    logic [MAN_W:0]         s1_man_b;
    logic [TAG_W-1:0]       s1_tag;

    logic                   s2_valid;
    logic                   s2_sign;
    fp_class_t              s2_cls;
    logic signed [SW-1:0]   s2_esum;
    logic [PW-1:0]          s2_product;
    logic [TAG_W-1:0]       s2_tag;

    logic [W-1:0]           rnd_result;
    logic [3:0]             rnd_flags;

    // One global enable: every stage moves only when the output slot can take a result.
    assign in_ready = !out_valid | out_ready;
    assign advance  = in_ready;

    always_comb begin
        cls_a  = classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
        cls_b  = classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
        esum_c = SW'(in_a[W-2:MAN_W]) + SW'(in_b[W-2:MAN_W]) - SW'(BIAS);
        if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == INF) ||
            (cls_a == INF && cls_b == ZERO))
            cls_c = NAN;
        else if (cls_a == INF || cls_b == INF)
            cls_c = INF;
        else if (cls_a == ZERO || cls_b == ZERO)
            cls_c = ZERO;
        else
            cls_c = NORM;
    end

    fpu_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .product (s2_product),
        .esum    (s2_esum),
        .sign    (s2_sign),
        .cls     (s2_cls),
        .result  (rnd_result),
        .flags   (rnd_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_cls     <= ZERO;
            s1_esum    <= '0;
            s1_man_a   <= '0;
            s1_man_b   <= '0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_cls     <= ZERO;
            s2_esum    <= '0;
            s2_product <= '0;
            s2_tag     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_flags  <= '0;
        end else if (advance) begin
            s1_valid   <= in_valid;
            s1_sign    <= in_a[W-1] ^ in_b[W-1];
            s1_cls     <= cls_c;
            s1_esum    <= esum_c;
            s1_man_a   <= {1'b1, in_a[MAN_W-1:0]};
            s1_man_b   <= {1'b1, in_b[MAN_W-1:0]};
            s1_tag     <= in_tag;

            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_cls     <= s1_cls;
            s2_esum    <= s1_esum;
            s2_product <= s1_man_a * s1_man_b;
            s2_tag     <= s1_tag;

            out_valid  <= s2_valid;
            out_result <= rnd_result;
            out_tag    <= s2_tag;
            out_flags  <= rnd_flags;
        end
    end

endmodule

// File: tb/tb_fpu_multiplier_pipelined.sv
// tb/tb_fpu_multiplier_pipelined.sv - randomized scoreboard bench for the pipelined multiplier
module tb_fpu_multiplier_pipelined;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  t;
        logic [3:0]  f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    int   pat_idx = 0;
    logic [3:0] pat = 4'b1001;

    fpu_multiplier_pipelined #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded remainder to one half.
    function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        exp_t   e;
        logic   s, za, zb, ia, ib, na, nb;
        longint p, q, rem, half;
        int     ex, sh;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        e.t = tag;
        e.f = 4'b0000;
        if (na || nb || (za && ib) || (ia && zb)) begin
            e.r = 32'h7FC00000;
            e.f = 4'b1000;
        end else if (ia || ib) begin
            e.r = {s, 8'hFF, 23'd0};
        end else if (za || zb) begin
            e.r = {s, 31'd0};
        end else begin
            p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            ex = int'(a[30:23]) + int'(b[30:23]) - 127;
            sh = 23;
            if (p >= (longint'(1) << 47)) begin
                sh = 24;
                ex++;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0]))
                q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                ex++;
            end
            if (ex >= 255) begin
                e.r = {s, 8'hFF, 23'd0};
                e.f = 4'b0101;
            end else if (ex <= 0) begin
                e.r = {s, 31'd0};
                e.f = 4'b0011;
            end else begin
                e.r = {s, ex[7:0], q[22:0]};
                e.f = {3'b000, rem != 0};
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  ex;
        logic [22:0] fr;
        int sel;
        sel = $urandom_range(0, 15);
        fr  = 23'($urandom);
        if ($urandom_range(0, 7) == 0)
            fr = '0;
        case (sel)
            0:       ex = 8'd0;
            1:       ex = 8'hFF;
            2:       ex = 8'($urandom_range(1, 5));
            3:       ex = 8'($urandom_range(250, 254));
            default: ex = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), ex, fr};
    endfunction

    task automatic set_ready();
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = pat[3 - (pat_idx % 4)];
                pat_idx++;
            end
            default: out_ready = 1'($urandom);
        endcase
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_ready();
            @(negedge clk);
        end
    endtask

    // Entered at a falling edge; returns at the falling edge after the operation was accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = e.t;
        for (int tries = 0; tries < 100; tries++) begin
            set_ready();
            #1;
            if (in_ready && rst_n) begin
                exp_q.push_back(e);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stuck low, expected 1 within 100 cycles");
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        send(a, b, ref_mul(a, b, tag));
    endtask

    task automatic send_const(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                              input logic [31:0] r, input logic [3:0] f);
        exp_t e;
        e.r = r;
        e.t = tag;
        e.f = f;
        send(a, b, e);
    endtask

    task automatic drain(input string name);
        int n;
        in_valid = 1'b0;
        rdy_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            set_ready();
            @(negedge clk);
            n++;
        end
        idle(6);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples mid-cycle, after the driver has settled the inputs for the next edge.
    initial begin
        logic        prev_rst = 1'b1;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_r = '0;
        logic [3:0]  prev_t = '0;
        logic [3:0]  prev_f = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !prev_rst) begin
                chk("reset_out_valid", 32'(out_valid), 32'd0);
                chk("reset_in_ready", 32'(in_ready), 32'd1);
                chk("reset_outputs", {out_result[23:0], out_tag, out_flags}, 32'd0);
                chk("reset_result_hi", 32'(out_result[31:24]), 32'd0);
            end
            if (rst_n && prev_rst && prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_result", out_result, prev_r);
                chk("stall_tag_flags", {24'd0, out_tag, out_flags}, {24'd0, prev_t, prev_f});
            end
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h tag %h, expected no output", out_result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", out_result, e.r);
                    chk("tag", 32'(out_tag), 32'(e.t));
                    chk("flags", 32'(out_flags), 32'(e.f));
                end
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_r     = out_result;
            prev_t     = out_tag;
            prev_f     = out_flags;
            prev_rst   = rst_n;
        end
    end

    initial begin
        int   lat;
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First-result latency with no backpressure.
        e.r = 32'h40400000;
        e.t = 4'h1;
        e.f = 4'b0000;
        in_valid = 1'b1;
        in_a = 32'h3FC00000;
        in_b = 32'h40000000;
        in_tag = e.t;
        out_ready = 1'b1;
        #1;
        if (in_ready)
            exp_q.push_back(e);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #2;
            if (out_valid && lat == 0)
                lat = k;
        end
        chk("latency", 32'(lat), 32'd3);
        @(negedge clk);

        rdy_mode = 0;
        send_const(32'hC0000000, 32'h40400000, 4'h2, 32'hC0C00000, 4'b0000);
        send_const(32'h3F800001, 32'h3F800001, 4'h3, 32'h3F800002, 4'b0001);
        send_const(32'h7F000000, 32'h7F000000, 4'h4, 32'h7F800000, 4'b0101);
        send_const(32'h00800000, 32'h00800000, 4'h5, 32'h00000000, 4'b0011);
        send_const(32'h00000000, 32'h7F800000, 4'h6, 32'h7FC00000, 4'b1000);
        drain("drain_directed");

        // Back-to-back burst under 1,0,0,1 backpressure with a reset in the middle.
        rdy_mode = 1;
        pat_idx = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                rst_n = 1'b0;
                in_valid = 1'b0;
                exp_q.delete();
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            send_model(rand_op(), rand_op(), 4'($urandom));
        end
        drain("drain_burst");

        // Random traffic with random gaps and random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send_model(rand_op(), rand_op(), 4'($urandom));
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
        end
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
